// File: rtl/wait_state_data_memory.sv
// wait_state_data_memory
//   Word-organised data memory for the RV32 data port with byte lanes,
//   sign/zero extension, a registered read result and a programmable number
//   of wait states between request acceptance and the one-cycle response.
//   Optional build macro: MEMORY_ERROR_EN -- when defined, misaligned,
//   out-of-range and reserved-option accesses complete with memory_error set,
//   perform no write and return zero. When undefined, memory_error is 0 and
//   such accesses use the plain lane rules with address wrap-around.
module wait_state_data_memory #(
   parameter string MEMORY_FILE = "",
   parameter int    MEMORY_SIZE = 4096,
   parameter int    WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [2:0]  option,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic        memory_response,
   output logic [31:0] read_data,
   output logic        memory_busy,
   output logic        memory_error
);

   localparam int DEPTH = MEMORY_SIZE / 4;
   localparam int AW    = $clog2(MEMORY_SIZE);
   localparam int IW    = (AW > 2) ? AW - 2 : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State and storage
   // ------------------------------------------------------------------
   state_t      state_reg, state_next;
   logic [3:0]  count_reg, count_next;
   logic        accept;
   logic        enter_resp;

   logic        req_write_reg;
   logic [2:0]  option_reg;
   logic [31:0] address_reg;
   logic [31:0] wdata_reg;
   logic [31:0] read_data_reg;

   logic [31:0] mem [DEPTH];

   // ------------------------------------------------------------------
   // Effective access: with zero wait states the access completes on the
   // acceptance edge itself, so the live request is used while idle and the
   // latched copy afterwards.
   // ------------------------------------------------------------------
   logic        acc_write;
   logic [2:0]  acc_option;
   logic [31:0] acc_address;
   logic [31:0] acc_wdata;

   assign acc_write   = (state_reg == S_IDLE) ? memory_write : req_write_reg;
   assign acc_option  = (state_reg == S_IDLE) ? option       : option_reg;
   assign acc_address = (state_reg == S_IDLE) ? address      : address_reg;
   assign acc_wdata   = (state_reg == S_IDLE) ? write_data   : wdata_reg;

   // Access size decode; the reserved codes fall through to a word access.
   logic size_byte, size_half, size_word;
   logic [1:0] lane;

   assign size_byte = (acc_option[1:0] == 2'b00);
   assign size_half = (acc_option[1:0] == 2'b01);
   assign size_word = ~size_byte & ~size_half;
   assign lane      = acc_address[1:0];

   // Word index; bits above the array depth are dropped so addresses wrap.
   logic [IW-1:0] acc_index;

   generate
      if (AW > 2) begin : g_index
         assign acc_index = acc_address[AW-1:2];
      end else begin : g_index_single
         assign acc_index = '0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Fault detection
   // ------------------------------------------------------------------
   logic access_fault;

`ifdef MEMORY_ERROR_EN
   logic opt_reserved;
   logic misaligned;
   logic out_of_range;

   assign opt_reserved = (acc_option == 3'b011) | (acc_option == 3'b110) |
                         (acc_option == 3'b111);
   assign misaligned   = (size_half & lane[0]) | (size_word & (lane != 2'b00));
   assign out_of_range = ({1'b0, acc_address} >= 33'(MEMORY_SIZE));
   assign access_fault = opt_reserved | misaligned | out_of_range;
`else
   assign access_fault = 1'b0;

   // Upper address bits play no role when accesses simply wrap.
   generate
      if (AW < 32) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^acc_address[31:AW];
      end
   endgenerate
`endif

   // ------------------------------------------------------------------
   // Write lanes: byte enables and the store data replicated into lanes
   // ------------------------------------------------------------------
   logic [3:0]      byte_en;
   logic [3:0][7:0] write_lane;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE_ID = 2'(gi);

         assign byte_en[gi] = size_word
                            | (size_half & (lane[1] == LANE_ID[1]))
                            | (size_byte & (lane == LANE_ID));

         assign write_lane[gi] = size_word ? acc_wdata[8*gi +: 8]
                               : size_half ? acc_wdata[8*(gi % 2) +: 8]
                               :             acc_wdata[7:0];
      end
   endgenerate

   logic commit;
   assign commit = enter_resp & acc_write & ~access_fault & ~reset;

   // ------------------------------------------------------------------
   // Load extraction from the addressed word
   // ------------------------------------------------------------------
   logic [31:0] read_word;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_value;

   assign read_word = mem[acc_index];
   assign sel_byte  = read_word[{lane, 3'b000} +: 8];
   assign sel_half  = lane[1] ? read_word[31:16] : read_word[15:0];

   // Sign-extend B/H, zero-extend BU/HU, pass words through.
   always_comb begin
      load_value = read_word;
      if (size_byte) begin
         load_value = {{24{~acc_option[2] & sel_byte[7]}}, sel_byte};
      end else if (size_half) begin
         load_value = {{16{~acc_option[2] & sel_half[15]}}, sel_half};
      end
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   // State and wait counter register; reset aborts any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
         count_reg <= 4'd0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   // Next-state logic: accept while idle, count wait states, pulse response.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      accept     = 1'b0;
      enter_resp = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (memory_read | memory_write) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_next = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = S_WAIT;
                  count_next = 4'(WAIT_STATES);
               end
            end
         end
         S_WAIT: begin
            count_next = count_reg - 4'd1;
            if (count_reg == 4'd1) begin
               state_next = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
            count_next = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   // Latch the request on acceptance; register the load result on entry to RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_write_reg <= 1'b0;
         option_reg    <= 3'd0;
         address_reg   <= 32'd0;
         wdata_reg     <= 32'd0;
         read_data_reg <= 32'd0;
      end else begin
         if (accept) begin
            req_write_reg <= memory_write;
            option_reg    <= option;
            address_reg   <= address;
            wdata_reg     <= write_data;
         end
         if (enter_resp) begin
            if (access_fault) begin
               read_data_reg <= 32'd0;
            end else if (!acc_write) begin
               read_data_reg <= load_value;
            end
         end
      end
   end

   // Array write with per-lane enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[acc_index][8*i +: 8] <= write_lane[i];
         end
      end
   end

`ifdef MEMORY_ERROR_EN
   logic error_reg;

   // Error flag is set alongside the response of a faulting access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_reg <= 1'b0;
      end else begin
         error_reg <= enter_resp & access_fault;
      end
   end

   assign memory_error = error_reg;
`else
   assign memory_error = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign memory_response = (state_reg == S_RESP);
   assign memory_busy     = (state_reg != S_IDLE);
   assign read_data       = read_data_reg;

endmodule

// File: tb/tb_wait_state_data_memory.sv
// tb_wait_state_data_memory
//   Two instances (0 and 3 wait states) share one request bus. A byte-level
//   reference memory per instance predicts load results, error flags and the
//   response/busy timing of every access.
module tb_wait_state_data_memory;

   localparam int MSIZE = 256;
   localparam int WS_A  = 0;
   localparam int WS_B  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        memory_read = 1'b0;
   logic        memory_write = 1'b0;
   logic [2:0]  option = 3'd0;
   logic [31:0] address = 32'd0;
   logic [31:0] write_data = 32'd0;

   logic [1:0]  resp_w, busy_w, err_w;
   logic [31:0] rd_w [2];

   int n_vec  = 0;
   int n_fail = 0;

   logic [7:0]  mem_m [2][MSIZE];
   logic [31:0] rd_exp [2];

   always #5 clk = ~clk;

   wait_state_data_memory #(.MEMORY_FILE(""), .MEMORY_SIZE(MSIZE), .WAIT_STATES(WS_A)) dut_a (
      .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
      .option(option), .address(address), .write_data(write_data),
      .memory_response(resp_w[0]), .read_data(rd_w[0]),
      .memory_busy(busy_w[0]), .memory_error(err_w[0]));

   wait_state_data_memory #(.MEMORY_FILE(""), .MEMORY_SIZE(MSIZE), .WAIT_STATES(WS_B)) dut_b (
      .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
      .option(option), .address(address), .write_data(write_data),
      .memory_response(resp_w[1]), .read_data(rd_w[1]),
      .memory_busy(busy_w[1]), .memory_error(err_w[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int acc_size(input logic [2:0] opt);
      case (opt[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit model_fault(input logic [2:0] opt, input logic [31:0] a);
`ifdef MEMORY_ERROR_EN
      int sz;
      sz = acc_size(opt);
      if (opt inside {3'b011, 3'b110, 3'b111}) return 1'b1;
      if ((a % 32'(sz)) != 0) return 1'b1;
      if (a >= 32'(MSIZE)) return 1'b1;
      return 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   // Base byte address: aligned down to the access size, wrapped into the memory.
   function automatic int unsigned model_base(input logic [2:0] opt, input logic [31:0] a);
      int unsigned sz;
      sz = int'(acc_size(opt));
      return ((a - (a % sz)) % MSIZE);
   endfunction

   function automatic logic [31:0] model_load(input int d, input logic [2:0] opt, input logic [31:0] a);
      int unsigned base;
      int sz;
      logic [31:0] val;
      base = model_base(opt, a);
      sz   = acc_size(opt);
      val  = 32'd0;
      for (int i = 0; i < sz; i++) val = val | ({24'd0, mem_m[d][(base + i) % MSIZE]} << (8 * i));
      if (sz == 1 && !opt[2] && val[7])  val = val | 32'hFFFF_FF00;
      if (sz == 2 && !opt[2] && val[15]) val = val | 32'hFFFF_0000;
      return val;
   endfunction

   task automatic model_store(input int d, input logic [2:0] opt, input logic [31:0] a, input logic [31:0] wd);
      int unsigned base;
      int sz;
      base = model_base(opt, a);
      sz   = acc_size(opt);
      for (int i = 0; i < sz; i++) mem_m[d][(base + i) % MSIZE] = wd[8*i +: 8];
   endtask

   // One access on the shared bus; request presented for a single edge.
   task automatic do_access(input bit wr, input logic [2:0] opt, input logic [31:0] a, input logic [31:0] wd);
      bit flt;
      int w;
      @(negedge clk);
      memory_read  = !wr;
      memory_write = wr;
      option       = opt;
      address      = a;
      write_data   = wd;
      flt = model_fault(opt, a);
      for (int d = 0; d < 2; d++) begin
         if (flt)     rd_exp[d] = 32'd0;
         else if (wr) model_store(d, opt, a, wd);
         else         rd_exp[d] = model_load(d, opt, a);
      end
      @(posedge clk);
      @(negedge clk);
      memory_read  = 1'b0;
      memory_write = 1'b0;
      for (int c = 1; c <= WS_B + 2; c++) begin
         if (c > 1) @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            w = (d == 0) ? WS_A : WS_B;
            check($sformatf("resp%0d_c%0d_%s_a%h", d, c, wr ? "st" : "ld", a), 32'(resp_w[d]), 32'(c == w + 1));
            check($sformatf("busy%0d_c%0d_a%h", d, c, a), 32'(busy_w[d]), 32'(c <= w + 1));
            if (c == w + 1) begin
               check($sformatf("rdata%0d_op%0d_a%h", d, opt, a), rd_w[d], rd_exp[d]);
               check($sformatf("err%0d_op%0d_a%h", d, opt, a), 32'(err_w[d]), 32'(flt));
            end else begin
               check($sformatf("err%0d_idle_c%0d", d, c), 32'(err_w[d]), 32'd0);
            end
         end
      end
   endtask

   initial begin
      logic [2:0] opt_tab [8];
      int cnt_a, cnt_b;
      opt_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      rd_exp[0] = 32'd0;
      rd_exp[1] = 32'd0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_resp", 32'(resp_w), 32'd0);
      check("reset_busy", 32'(busy_w), 32'd0);
      check("reset_err",  32'(err_w),  32'd0);
      check("reset_rd_a", rd_w[0], 32'd0);
      check("reset_rd_b", rd_w[1], 32'd0);
      reset = 1'b0;

      // Fill the whole array with known words
      for (int i = 0; i < MSIZE / 4; i++) do_access(1'b1, 3'b010, 32'(i * 4), $urandom);

      // Word store then load
      do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      do_access(1'b0, 3'b010, 32'h10, 32'd0);
      check("t1_lw_a", rd_w[0], 32'hDEADBEEF);
      check("t1_lw_b", rd_w[1], 32'hDEADBEEF);

      // Sub-word lanes and extension
      do_access(1'b1, 3'b010, 32'h20, 32'h11223344);
      do_access(1'b1, 3'b000, 32'h21, 32'h000000AA);
      do_access(1'b0, 3'b010, 32'h20, 32'd0);
      check("t3_lw", rd_w[1], 32'h1122AA44);
      do_access(1'b0, 3'b000, 32'h21, 32'd0);
      check("t3_lb", rd_w[1], 32'hFFFFFFAA);
      do_access(1'b0, 3'b100, 32'h21, 32'd0);
      check("t3_lbu", rd_w[1], 32'h000000AA);
      do_access(1'b0, 3'b001, 32'h22, 32'd0);
      check("t3_lh", rd_w[1], 32'h00001122);

`ifndef MEMORY_ERROR_EN
      // Misaligned accesses fall back to lane rules; addresses wrap
      do_access(1'b0, 3'b001, 32'h23, 32'd0);
      check("mis_lh", rd_w[0], 32'h00001122);
      do_access(1'b0, 3'b010, 32'h21, 32'd0);
      check("mis_lw", rd_w[0], 32'h1122AA44);
      do_access(1'b1, 3'b010, 32'(MSIZE + 'h14), 32'h0BADF00D);
      do_access(1'b0, 3'b010, 32'h14, 32'd0);
      check("wrap_lw", rd_w[1], 32'h0BADF00D);
`else
      // Faulting accesses: error with response, zero data, no write
      do_access(1'b0, 3'b010, 32'h2, 32'd0);
      check("t5_lw_mis_rd", rd_w[1], 32'd0);
      do_access(1'b1, 3'b010, 32'(MSIZE), 32'h12345678);
      do_access(1'b0, 3'b010, 32'h0, 32'd0);
`endif

      // Request held through busy with read and write both high
      @(negedge clk);
      memory_read  = 1'b1;
      memory_write = 1'b1;
      option       = 3'b010;
      address      = 32'h40;
      write_data   = 32'h5A5AA5A5;
      for (int d = 0; d < 2; d++) model_store(d, 3'b010, 32'h40, 32'h5A5AA5A5);
      cnt_a = 0;
      cnt_b = 0;
      for (int c = 1; c <= WS_B + 3; c++) begin
         @(negedge clk);
         if (resp_w[0]) cnt_a++;
         if (resp_w[1]) cnt_b++;
         if (c == WS_B + 1) begin
            check("t6_rd_held", rd_w[1], rd_exp[1]);
            memory_read  = 1'b0;
            memory_write = 1'b0;
         end
      end
      check("t6_b_responses", 32'(cnt_b), 32'd1);
      check("t6_a_responses", 32'(cnt_a), 32'd2);
      do_access(1'b0, 3'b010, 32'h40, 32'd0);
      check("t6_lw", rd_w[1], 32'h5A5AA5A5);

      // Reset one cycle after acceptance aborts the slow instance's store
      @(negedge clk);
      memory_write = 1'b1;
      option       = 3'b010;
      address      = 32'h30;
      write_data   = 32'hCAFEF00D;
      model_store(0, 3'b010, 32'h30, 32'hCAFEF00D);
      @(posedge clk);
      @(negedge clk);
      memory_write = 1'b0;
      reset = 1'b1;
      #1;
      check("t4_busy", 32'(busy_w), 32'd0);
      check("t4_resp", 32'(resp_w), 32'd0);
      check("t4_rd_b", rd_w[1], 32'd0);
      rd_exp[0] = 32'd0;
      rd_exp[1] = 32'd0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < WS_B + 2; c++) begin
         @(negedge clk);
         check($sformatf("t4_noresp_c%0d", c), 32'(resp_w), 32'd0);
      end
      do_access(1'b0, 3'b010, 32'h30, 32'd0);
      check("t4_lw_a", rd_w[0], 32'hCAFEF00D);

      // Randomised accesses against the reference model
      for (int i = 0; i < 40; i++) begin
         do_access(1'($urandom_range(0, 1)), opt_tab[$urandom_range(0, 7)],
                   32'($urandom_range(0, 2 * MSIZE - 1)), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
